// File: rtl/brisc_pkg.sv
// Shared cache definitions: flush-engine states, default geometry and address-split helpers.
package brisc_pkg;

    localparam int unsigned BYTE_LEN       = 8;
    localparam int unsigned REG_LEN        = 32;
    localparam int unsigned CACHE_LINE_LEN = 128;
    localparam int unsigned ADDRESS_BITS   = 32;
    localparam int unsigned DEF_NUM_SETS   = 4;
    localparam int unsigned DEF_NUM_WAYS   = 2;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} cache_state_e;

    // Extracts addr[lsb +: width], zero-extended to the full address width.
    function automatic logic [ADDRESS_BITS-1:0] addr_field(input logic [ADDRESS_BITS-1:0] addr,
                                                           input int unsigned lsb,
                                                           input int unsigned width);
        logic [ADDRESS_BITS-1:0] mask;
        mask = {ADDRESS_BITS{1'b1}} >> (ADDRESS_BITS - width);
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age vector for one set: touched way becomes youngest, the oldest way is the victim.
module cache_lru #(
    parameter int unsigned NUM_WAYS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        touch_en,
    input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim
);
    localparam int unsigned WAY_BITS = $clog2(NUM_WAYS);

    logic [WAY_BITS-1:0] age_q [NUM_WAYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= WAY_BITS'(w);
        end else if (touch_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_BITS'(w) == touch_way) begin
                    age_q[w] <= '0;
                end else if (age_q[w] < age_q[touch_way]) begin
                    age_q[w] <= age_q[w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[w] == WAY_BITS'(NUM_WAYS - 1)) victim = WAY_BITS'(w);
        end
    end

endmodule

// File: rtl/cache_set_store.sv
// N-way set-associative line store with true-LRU replacement, dirty-victim eviction
// handshake and a sequential flush engine.
module cache_set_store
    import brisc_pkg::*;
#(
    parameter int unsigned NUM_SETS  = DEF_NUM_SETS,
    parameter int unsigned NUM_WAYS  = DEF_NUM_WAYS,
    parameter int unsigned LINE_BITS = CACHE_LINE_LEN,
    parameter int unsigned WORD_BITS = REG_LEN,
    parameter int unsigned ADDR_BITS = ADDRESS_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lookup_en,
    input  logic [ADDR_BITS-1:0]        lookup_addr,
    output logic                        hit,
    output logic [$clog2(NUM_WAYS)-1:0] hit_way,
    output logic [WORD_BITS-1:0]        rd_word,
    input  logic                        wr_en,
    input  logic [ADDR_BITS-1:0]        wr_addr,
    input  logic [WORD_BITS-1:0]        wr_data,
    output logic                        wr_hit,
    input  logic                        fill_en,
    input  logic [ADDR_BITS-1:0]        fill_addr,
    input  logic [LINE_BITS-1:0]        fill_line,
    output logic                        fill_ready,
    input  logic                        flush_req,
    output logic                        busy,
    output logic                        flush_done,
    output logic                        evict_valid,
    input  logic                        evict_ready,
    output logic [ADDR_BITS-1:0]        evict_addr,
    output logic [LINE_BITS-1:0]        evict_line
);
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / BYTE_LEN);
    localparam int unsigned INDEX_BITS  = $clog2(NUM_SETS);
    localparam int unsigned TAG_BITS    = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
    localparam int unsigned WORDS       = LINE_BITS / WORD_BITS;
    localparam int unsigned WSEL_LSB    = $clog2(WORD_BITS / BYTE_LEN);
    localparam int unsigned WSEL_BITS   = $clog2(WORDS);
    localparam int unsigned WAY_BITS    = $clog2(NUM_WAYS);
    localparam int unsigned ENTRY_BITS  = INDEX_BITS + WAY_BITS;
    localparam int unsigned TAG_LSB     = OFFSET_BITS + INDEX_BITS;

    cache_state_e state_q;
    logic [ENTRY_BITS-1:0] entry_q;
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [TAG_BITS-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0]  data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]   lru_victim [NUM_SETS];

    logic [INDEX_BITS-1:0] lk_idx, wr_idx, fl_idx, touch_set, fsh_set;
    logic [TAG_BITS-1:0]   lk_tag, wr_tag, fl_tag;
    logic [WSEL_BITS-1:0]  lk_wsel, wr_wsel;
    logic [WAY_BITS-1:0]   lk_way, wr_way, fl_victim, fl_inv_way, touch_way, fsh_way;
    logic                  lk_hit, fl_has_inv, touch_en;
    logic                  do_flush, do_fill, do_store, do_lookup, any_req;
    logic [WORDS-1:0][WORD_BITS-1:0] lk_words, wr_words;

    assign lk_idx  = INDEX_BITS'(addr_field(ADDRESS_BITS'(lookup_addr), OFFSET_BITS, INDEX_BITS));
    assign lk_tag  = TAG_BITS'(addr_field(ADDRESS_BITS'(lookup_addr), TAG_LSB, TAG_BITS));
    assign lk_wsel = WSEL_BITS'(addr_field(ADDRESS_BITS'(lookup_addr), WSEL_LSB, WSEL_BITS));
    assign wr_idx  = INDEX_BITS'(addr_field(ADDRESS_BITS'(wr_addr), OFFSET_BITS, INDEX_BITS));
    assign wr_tag  = TAG_BITS'(addr_field(ADDRESS_BITS'(wr_addr), TAG_LSB, TAG_BITS));
    assign wr_wsel = WSEL_BITS'(addr_field(ADDRESS_BITS'(wr_addr), WSEL_LSB, WSEL_BITS));
    assign fl_idx  = INDEX_BITS'(addr_field(ADDRESS_BITS'(fill_addr), OFFSET_BITS, INDEX_BITS));
    assign fl_tag  = TAG_BITS'(addr_field(ADDRESS_BITS'(fill_addr), TAG_LSB, TAG_BITS));
    assign fsh_set = entry_q[ENTRY_BITS-1 -: INDEX_BITS];
    assign fsh_way = entry_q[WAY_BITS-1:0];

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        wr_hit = 1'b0;
        wr_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!lk_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_BITS'(w);
            end
            if (!wr_hit && valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
                wr_hit = 1'b1;
                wr_way = WAY_BITS'(w);
            end
        end
    end

    // Invalid ways are always preferred over the LRU choice.
    always_comb begin
        fl_has_inv = 1'b0;
        fl_inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!fl_has_inv && !valid_q[fl_idx][w]) begin
                fl_has_inv = 1'b1;
                fl_inv_way = WAY_BITS'(w);
            end
        end
        fl_victim = fl_has_inv ? fl_inv_way : lru_victim[fl_idx];
    end

    assign lk_words = data_q[lk_idx][lk_way];

    always_comb begin
        wr_words          = data_q[wr_idx][wr_way];
        wr_words[wr_wsel] = wr_data;
    end

    assign fill_ready = (state_q == IDLE) && !evict_valid;
    assign any_req    = flush_req || fill_en || wr_en || lookup_en;
    assign do_flush   = flush_req && fill_ready;
    assign do_fill    = !flush_req && fill_en && fill_ready;
    assign do_store   = !flush_req && !fill_en && wr_en && wr_hit && (state_q == IDLE);
    assign do_lookup  = !flush_req && !fill_en && !wr_en && lookup_en && (state_q == IDLE);

    always_comb begin
        touch_en  = 1'b0;
        touch_set = lk_idx;
        touch_way = lk_way;
        if (do_fill) begin
            touch_en  = 1'b1;
            touch_set = fl_idx;
            touch_way = fl_victim;
        end else if (do_store) begin
            touch_en  = 1'b1;
            touch_set = wr_idx;
            touch_way = wr_way;
        end else if (do_lookup && lk_hit) begin
            touch_en  = 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
        cache_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
            .clk       (clk),
            .rst_n     (rst_n),
            .touch_en  (touch_en && (touch_set == INDEX_BITS'(s))),
            .touch_way (touch_way),
            .victim    (lru_victim[s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            busy        <= 1'b0;
            flush_done  <= 1'b0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_line  <= '0;
            hit         <= 1'b0;
            hit_way     <= '0;
            rd_word     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            flush_done <= 1'b0;
            if (evict_valid && evict_ready) evict_valid <= 1'b0;

            if (do_lookup) begin
                hit     <= lk_hit;
                hit_way <= lk_way;
                rd_word <= lk_words[lk_wsel];
            end else if (any_req) begin
                hit <= 1'b0;
            end

            if (do_store) dirty_q[wr_idx][wr_way] <= 1'b1;

            if (do_fill) begin
                valid_q[fl_idx][fl_victim] <= 1'b1;
                dirty_q[fl_idx][fl_victim] <= 1'b0;
                if (valid_q[fl_idx][fl_victim] && dirty_q[fl_idx][fl_victim]) begin
                    evict_valid <= 1'b1;
                    evict_addr  <= {tag_q[fl_idx][fl_victim], fl_idx, {OFFSET_BITS{1'b0}}};
                    evict_line  <= data_q[fl_idx][fl_victim];
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (do_flush) begin
                        state_q <= SCAN;
                        entry_q <= '0;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    valid_q[fsh_set][fsh_way] <= 1'b0;
                    dirty_q[fsh_set][fsh_way] <= 1'b0;
                    if (valid_q[fsh_set][fsh_way] && dirty_q[fsh_set][fsh_way]) begin
                        evict_valid <= 1'b1;
                        evict_addr  <= {tag_q[fsh_set][fsh_way], fsh_set, {OFFSET_BITS{1'b0}}};
                        evict_line  <= data_q[fsh_set][fsh_way];
                        state_q     <= WAIT;
                    end else if (entry_q == ENTRY_BITS'(NUM_SETS * NUM_WAYS - 1)) begin
                        state_q    <= DONE;
                        flush_done <= 1'b1;
                    end else begin
                        entry_q <= entry_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (evict_ready) begin
                        if (entry_q == ENTRY_BITS'(NUM_SETS * NUM_WAYS - 1)) begin
                            state_q    <= DONE;
                            flush_done <= 1'b1;
                        end else begin
                            entry_q <= entry_q + 1'b1;
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags and line data carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[fl_idx][fl_victim]  <= fl_tag;
            data_q[fl_idx][fl_victim] <= fill_line;
        end else if (do_store) begin
            data_q[wr_idx][wr_way] <= wr_words;
        end
    end

endmodule

// File: tb/tb_cache_set_store.sv
// Scoreboarded bench for cache_set_store: lookups and evictions are checked by a monitor.
module tb_cache_set_store;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lookup_en = 1'b0;
    logic [31:0]  lookup_addr = '0;
    logic         hit;
    logic         hit_way;
    logic [31:0]  rd_word;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         wr_hit;
    logic         fill_en = 1'b0;
    logic [31:0]  fill_addr = '0;
    logic [127:0] fill_line = '0;
    logic         fill_ready;
    logic         flush_req = 1'b0;
    logic         busy;
    logic         flush_done;
    logic         evict_valid;
    logic         evict_ready = 1'b0;
    logic [31:0]  evict_addr;
    logic [127:0] evict_line;

    cache_set_store dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_en   (lookup_en),
        .lookup_addr (lookup_addr),
        .hit         (hit),
        .hit_way     (hit_way),
        .rd_word     (rd_word),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_hit      (wr_hit),
        .fill_en     (fill_en),
        .fill_addr   (fill_addr),
        .fill_line   (fill_line),
        .fill_ready  (fill_ready),
        .flush_req   (flush_req),
        .busy        (busy),
        .flush_done  (flush_done),
        .evict_valid (evict_valid),
        .evict_ready (evict_ready),
        .evict_addr  (evict_addr),
        .evict_line  (evict_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic        way;
        logic [31:0] word;
    } lk_exp_t;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
    } ev_exp_t;

    lk_exp_t lk_q[$];
    ev_exp_t ev_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    bit      lk_sent;

    localparam logic [127:0] L1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] L2 = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
    localparam logic [127:0] L3 = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    localparam logic [127:0] L4 = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    localparam logic [127:0] EV1 = {32'h4444_4444, 32'h3333_3333, 32'h1234_5678, 32'h1111_1111};
    localparam logic [127:0] EV3 = {32'h3000_0003, 32'hDEAD_BEEF, 32'h3000_0001, 32'h3000_0000};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A lookup issued alone at an edge has its response visible at the following negedge.
    always @(posedge clk) lk_sent <= lookup_en && !fill_en && !wr_en && !flush_req;

    always @(negedge clk) begin
        lk_exp_t le;
        ev_exp_t ee;
        if (lk_sent) begin
            if (lk_q.size() == 0) begin
                check("lookup_unexpected", 1, 0);
            end else begin
                le = lk_q.pop_front();
                check($sformatf("hit@%0h", le.addr), hit, le.hit);
                if (le.hit) begin
                    check($sformatf("hit_way@%0h", le.addr), hit_way, le.way);
                    check($sformatf("rd_word@%0h", le.addr), rd_word, le.word);
                end
            end
        end
        if (evict_valid && evict_ready) begin
            if (ev_q.size() == 0) begin
                check("evict_unexpected", 1, 0);
            end else begin
                ee = ev_q.pop_front();
                check("evict_addr", evict_addr, ee.addr);
                check("evict_line", evict_line, ee.line);
            end
        end
    end

    task automatic lookup(input logic [31:0] a, input logic h, input logic w, input logic [31:0] d);
        lk_q.push_back('{addr: a, hit: h, way: w, word: d});
        lookup_en   = 1'b1;
        lookup_addr = a;
        tick();
        lookup_en = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input logic [127:0] line);
        int n = 0;
        while (!fill_ready && n < 50) begin
            tick();
            n++;
        end
        check("fill_ready_wait", fill_ready, 1);
        fill_en   = 1'b1;
        fill_addr = a;
        fill_line = line;
        tick();
        fill_en = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check($sformatf("wr_hit@%0h", a), wr_hit, exp_hit);
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        int done_cnt;
        int done_at;
        int n;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_hit", hit, 0);
        check("rst_hit_way", hit_way, 0);
        check("rst_rd_word", rd_word, 0);
        check("rst_evict_valid", evict_valid, 0);
        check("rst_fill_ready", fill_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flush_done", flush_done, 0);
        lookup(32'h0000_1040, 0, 0, 0);

        fill(32'h1040, L1);
        lookup(32'h1048, 1, 0, 32'h3333_3333);

        fill(32'h2040, L2);
        lookup(32'h1040, 1, 0, 32'h1111_1111);
        // Lookup colliding with a fill is dropped and does not touch LRU.
        lookup_en   = 1'b1;
        lookup_addr = 32'h1040;
        fill(32'h3040, L3);
        lookup_en = 1'b0;
        check("dropped_lookup_hit", hit, 0);
        check("fill3040_no_evict", evict_valid, 0);
        lookup(32'h2040, 0, 0, 0);
        lookup(32'h1040, 1, 0, 32'h1111_1111);
        lookup(32'h304C, 1, 1, 32'h3000_0003);

        store(32'h1044, 32'h1234_5678, 1);
        store(32'h5040, 32'hFFFF_FFFF, 0);
        lookup(32'h1044, 1, 0, 32'h1234_5678);
        lookup(32'h3040, 1, 1, 32'h3000_0000);
        ev_q.push_back('{addr: 32'h1040, line: EV1});
        fill(32'h4040, L4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("evict_valid_hold%0d", i), evict_valid, 1);
            check($sformatf("evict_addr_hold%0d", i), evict_addr, 32'h1040);
            check($sformatf("evict_line_hold%0d", i), evict_line, EV1);
            check($sformatf("fill_ready_low%0d", i), fill_ready, 0);
        end
        tick();
        lookup(32'h4044, 1, 0, 32'h4000_0001);
        evict_ready = 1'b1;
        tick();
        evict_ready = 1'b0;
        check("evict_dropped", evict_valid, 0);
        check("fill_ready_back", fill_ready, 1);

        store(32'h3048, 32'hDEAD_BEEF, 1);
        ev_q.push_back('{addr: 32'h3040, line: EV3});
        evict_ready = 1'b1;
        flush_req   = 1'b1;
        tick();
        flush_req   = 1'b0;
        busy_cycles = 0;
        done_cnt    = 0;
        done_at     = 0;
        n           = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (busy) busy_cycles++;
            if (flush_done) begin
                done_cnt++;
                done_at = busy_cycles;
            end
            if (!busy) break;
        end
        tick();
        evict_ready = 1'b0;
        check("flush_busy_cycles", busy_cycles, 10);
        check("flush_done_count", done_cnt, 1);
        check("flush_done_at", done_at, 10);
        check("flush_evictions_left", ev_q.size(), 0);
        lookup(32'h4040, 0, 0, 0);
        lookup(32'h3040, 0, 0, 0);
        lookup(32'h1040, 0, 0, 0);

        fill(32'h1040, L1);
        store(32'h1040, 32'hAAAA_AAAA, 1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        while (!evict_valid && n < 20) begin
            tick();
            n++;
        end
        check("flush_wait_evict_valid", evict_valid, 1);
        check("flush_wait_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_evict_valid", evict_valid, 0);
        check("mid_rst_fill_ready", fill_ready, 1);
        #1;
        rst_n = 1'b1;
        tick();
        lookup(32'h1040, 0, 0, 0);

        repeat (3) tick();
        check("lookup_queue_drained", lk_q.size(), 0);
        check("evict_queue_drained", ev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_set_store.md
# cache_set_store

Parametrised N-way set-associative cache storage array with per-line valid/dirty/tag state, multi-word lines, true-LRU replacement, dirty-victim eviction handshake and a sequential flush engine. It is the storage core of the instruction and data caches: the cache controller issues lookups, word stores, line fills and flushes, and the memory side drains evicted dirty lines.

## Interface
Parameters:
- NUM_SETS, 4, sets; power of two, ≥ 2.
- NUM_WAYS, 2, ways per set; power of two, ≥ 2.
- LINE_BITS, CACHE_LINE_LEN, line width in bits.
- WORD_BITS, REG_LEN, word width for reads and stores.
- ADDR_BITS, ADDRESS_BITS, byte address width.
- Derived: OFFSET_BITS = $clog2(LINE_BITS/BYTE_LEN), INDEX_BITS = $clog2(NUM_SETS), TAG_BITS = ADDR_BITS-OFFSET_BITS-INDEX_BITS, WORDS = LINE_BITS/WORD_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_en  in  1  read request.
- lookup_addr  in  ADDR_BITS  read byte address.
- hit  out  1  registered lookup result.
- hit_way  out  $clog2(NUM_WAYS)  way that hit.
- rd_word  out  WORD_BITS  addressed word of the hit line.
- wr_en  in  1  word store request.
- wr_addr  in  ADDR_BITS  store address.
- wr_data  in  WORD_BITS  store data.
- wr_hit  out  1  combinational: store address is resident.
- fill_en  in  1  line fill request.
- fill_addr  in  ADDR_BITS  fill line address.
- fill_line  in  LINE_BITS  fill data.
- fill_ready  out  1  fill/flush can be accepted.
- flush_req  in  1  start flush, accepted with fill_ready.
- busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse at flush end.
- evict_valid  out  1  dirty victim presented.
- evict_ready  in  1  memory side accepts victim.
- evict_addr  out  ADDR_BITS  {tag, index, OFFSET_BITS'0}.
- evict_line  out  LINE_BITS  victim data.

## Operation
- Address split: offset = addr[OFFSET_BITS-1:0], word select = offset[OFFSET_BITS-1:$clog2(WORD_BITS/BYTE_LEN)], index next INDEX_BITS, tag upper TAG_BITS. Word 0 = line[WORD_BITS-1:0].
- Per-cycle priority: flush_req > fill_en > wr_en > lookup_en; lower requests in the same cycle are dropped (no effect, hit=0).
- Lookup: compare tag against all valid ways of the set; hit updates that way's LRU age.
- Store: if wr_hit, write word, set dirty, touch LRU; store miss ignored (no write-allocate).
- Fill (accepted when fill_en && fill_ready): victim = lowest-index invalid way, else way with age NUM_WAYS-1. Victim valid&dirty → copy into evict registers, evict_valid=1. Line written with valid=1, dirty=0, victim touched in LRU. Filling a resident tag still allocates victim; controller must not do so.
- LRU: per set, per way age of $clog2(NUM_WAYS) bits forming a permutation; touch way w: ages < age[w] increment, age[w]=0.
- Eviction: evict_valid/addr/line stable until evict_ready sampled high; fill_ready = IDLE && !evict_valid.
- Flush FSM: IDLE → SCAN (flush_req accepted) → walk entry e = set*NUM_WAYS+way, one per cycle; each scanned entry gets valid=0, dirty=0; if it was valid&dirty load evict regs and go WAIT; WAIT → SCAN at next entry on evict_ready; after last entry → DONE (flush_done=1 one cycle) → IDLE. busy=1 in SCAN/WAIT/DONE. Lookups/stores during busy are dropped.

## Timing
- Reset: valid=0, dirty=0, ages[way]=way, hit=0, hit_way=0, rd_word=0, evict_valid=0, busy=0, flush_done=0, state IDLE. Tags/data not reset.
- Lookup at edge N → hit/hit_way/rd_word valid after edge N+1, held until next lookup or dropped request (hit=0).
- Store/fill state visible to a lookup issued the cycle after the write.
- Fill with dirty victim: evict_valid rises the edge after accept; drops the edge evict_ready is sampled.
- Flush of a clean cache: busy for NUM_SETS*NUM_WAYS+1 cycles; each dirty line adds ≥ 1 WAIT cycle.
- rst_n low mid-flush or mid-eviction: immediate return to reset values; pending victim lost.

## Structure
- brisc_pkg: cache state enum (IDLE, SCAN, WAIT, DONE), default NUM_SETS/NUM_WAYS, address-split helper functions.
- Sub-module cache_lru: one set's age vector, touch input, victim output; instantiated NUM_SETS times.

## Test plan
- Reset, lookup 0x0000_1040 → hit=0 next cycle; evict_valid=0, fill_ready=1.
- Fill 0x1040 with words {0x4444_4444,0x3333_3333,0x2222_2222,0x1111_1111} (word3..0), lookup 0x1048 → hit=1, hit_way=0, rd_word=0x3333_3333.
- Fill 0x2040 (way 1), lookup 0x1040, fill 0x3040 → replaces way 1, evict_valid=0; lookup 0x2040 miss, 0x1040 hit.
- Store 0x1044 ← 0x1234_5678, lookup 0x3040, fill 0x4040 → evict_valid=1, evict_addr=0x1040, evict word1=0x1234_5678; evict_ready low 3 cycles → outputs stable, fill_ready=0.
- One dirty line resident, flush_req → exactly one eviction, flush_done pulse after ≥ 9 cycles, all later lookups miss.
- rst_n pulsed during flush WAIT → busy=0, evict_valid=0, lookup of previously resident line misses.
